// File: rtl/axi4_full_sub_mem.sv
// axi4_full_sub_mem: AXI4 INCR-burst subordinate over a small wrap-around word memory
module axi4_full_sub_mem #(
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0] w_idx, r_idx, r_nxt;
  logic [7:0] w_len, r_len, r_cnt;
  logic [8:0] w_cnt;
  logic w_hs, unused;
  assign w_hs = S_AXI_WVALID && S_AXI_WREADY;
  assign r_nxt = r_idx + 1'b1;
  assign S_AXI_RRESP = 2'b00;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  // beats past AWLEN+1 are still handshaken but must not touch memory
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (w_hs && w_cnt <= {1'b0, w_len}) begin
      for (int b = 0; b < C_S_AXI_DATA_WIDTH / 8; b++)
        if (S_AXI_WSTRB[b]) mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
    end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      w_state <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP <= 2'b00;
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
    end else begin
      case (w_state)
        W_IDLE:
          if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY <= 1'b1;
            w_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            w_len <= S_AXI_AWLEN;
            w_cnt <= '0;
            w_state <= W_DATA;
          end else S_AXI_AWREADY <= 1'b1;
        W_DATA:
          if (w_hs) begin
            w_idx <= w_idx + 1'b1;
            w_cnt <= w_cnt + {8'd0, ~&w_cnt};
            if (S_AXI_WLAST) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              S_AXI_BRESP <= (w_cnt != {1'b0, w_len}) ? 2'b10 : 2'b00;
              w_state <= W_RESP;
            end
          end
        W_RESP:
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP <= 2'b00;
            S_AXI_AWREADY <= 1'b1;
            w_state <= W_IDLE;
          end
        default: w_state <= W_IDLE;
      endcase
    end
  // RDATA is prefetched into a register, so a same-cycle write is not seen by that beat
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      r_state <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RLAST <= 1'b0;
      S_AXI_RDATA <= '0;
      r_idx <= '0;
      r_len <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        R_IDLE:
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA <= mem[S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]];
            S_AXI_RLAST <= (S_AXI_ARLEN == 8'd0);
            r_idx <= S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
            r_len <= S_AXI_ARLEN;
            r_cnt <= '0;
            r_state <= R_DATA;
          end else S_AXI_ARREADY <= 1'b1;
        R_DATA:
          if (S_AXI_RREADY) begin
            if (S_AXI_RLAST) begin
              S_AXI_RVALID <= 1'b0;
              S_AXI_RLAST <= 1'b0;
              S_AXI_RDATA <= '0;
              S_AXI_ARREADY <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_idx <= r_nxt;
              r_cnt <= r_cnt + 8'd1;
              S_AXI_RDATA <= mem[r_nxt];
              S_AXI_RLAST <= (r_cnt + 8'd1 == r_len);
            end
          end
        default: r_state <= R_IDLE;
      endcase
    end
endmodule

// File: tb/tb_axi4_full_sub_mem.sv
// tb_axi4_full_sub_mem: randomized bursts against a word-array model plus protocol monitor
module tb_axi4_full_sub_mem;
  logic clk = 0, rst_n = 1;
  logic [3:0] awaddr = 0, araddr = 0;
  logic [7:0] awlen = 0, arlen = 0;
  logic [2:0] awprot = 0, arprot = 0;
  logic awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = 0;
  logic [3:0] wstrb = 0;
  logic awready, wready, bvalid, arready, rvalid, rlast;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  int n_cmp = 0, n_bad = 0, viol = 0, r_lat = 0;
  logic [31:0] mem_m [4];
  logic [31:0] wd [512];
  logic [3:0] ws [512];
  logic [31:0] rd [256];
  logic rl [256];

  always #5 clk = ~clk;

  axi4_full_sub_mem #(.C_S_AXI_ADDR_WIDTH(4), .C_S_AXI_DATA_WIDTH(32)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  // protocol rules, evaluated mid-cycle once the bench has settled its inputs
  logic pbv = 0, pbr = 0, prv = 0, prr = 0, prl = 0, seen_wlast = 0;
  logic [1:0] pbresp = 0;
  logic [31:0] prd = 0;
  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      pbv = 0; prv = 0; seen_wlast = 0;
    end else begin
      if (awvalid && awready && wready) viol++;
      if (rvalid && arready) viol++;
      if (!rvalid && (rdata !== 32'd0 || rlast)) viol++;
      if (rresp !== 2'b00) viol++;
      if (bvalid && !seen_wlast) viol++;
      if (pbv && !pbr && (!bvalid || bresp !== pbresp)) viol++;
      if (prv && !prr && (!rvalid || rdata !== prd || rlast !== prl)) viol++;
      if (wvalid && wready && wlast) seen_wlast = 1;
      if (bvalid && bready) seen_wlast = 0;
      pbv = bvalid; pbr = bready; pbresp = bresp;
      prv = rvalid; prr = rready; prd = rdata; prl = rlast;
    end
  end

  function automatic void m_write(input logic [3:0] addr, input int len, input int nb);
    for (int i = 0; i < nb && i <= len; i++)
      for (int b = 0; b < 4; b++)
        if (ws[i][b]) mem_m[(int'(addr[3:2]) + i) % 4][8*b +: 8] = wd[i][8*b +: 8];
  endfunction

  task automatic stall_gap(input bit en);
    while (en && $urandom_range(3) == 0) @(negedge clk);
  endtask

  task automatic wr_req(input logic [3:0] addr, input int len, input int nb, input bit st);
    fork
      begin
        int n;
        stall_gap(st);
        awvalid = 1; awaddr = addr; awlen = 8'(len); awprot = 3'($urandom);
        n = 0;
        while (!awready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin n_cmp++; n_bad++; $display("FAIL aw_timeout awready=%b want 1", awready); end
        @(negedge clk); awvalid = 0;
      end
      begin
        for (int i = 0; i < nb; i++) begin
          int n;
          wvalid = 0; stall_gap(st);
          wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == nb - 1);
          n = 0;
          while (!wready && n < 300) begin @(negedge clk); n++; end
          if (n >= 300) begin n_cmp++; n_bad++; $display("FAIL w_timeout beat=%0d wready=%b want 1", i, wready); end
          @(negedge clk);
        end
        wvalid = 0; wlast = 0;
      end
    join
  endtask

  task automatic wr_resp(input bit st, output logic [1:0] resp);
    int n = 0;
    bready = st ? ($urandom_range(2) != 0) : 1'b1;
    while (!(bvalid && bready) && n < 300) begin
      @(negedge clk); n++;
      bready = st ? ($urandom_range(2) != 0) : 1'b1;
    end
    if (n >= 300) begin n_cmp++; n_bad++; $display("FAIL b_timeout bvalid=%b want 1", bvalid); end
    resp = bresp;
    @(negedge clk); bready = 0;
  endtask

  task automatic axi_read(input logic [3:0] addr, input int len, input bit st);
    int n = 0;
    stall_gap(st);
    arvalid = 1; araddr = addr; arlen = 8'(len); arprot = 3'($urandom);
    while (!arready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin n_cmp++; n_bad++; $display("FAIL ar_timeout arready=%b want 1", arready); end
    @(negedge clk); arvalid = 0;
    r_lat = 1;
    while (!rvalid && r_lat < 100) begin @(negedge clk); r_lat++; end
    for (int i = 0; i <= len; i++) begin
      rready = st ? ($urandom_range(2) != 0) : 1'b1;
      n = 0;
      while (!(rvalid && rready) && n < 300) begin
        @(negedge clk); n++;
        rready = st ? ($urandom_range(2) != 0) : 1'b1;
      end
      if (n >= 300) begin n_cmp++; n_bad++; $display("FAIL r_timeout beat=%0d rvalid=%b want 1", i, rvalid); end
      rd[i] = rdata; rl[i] = rlast;
      @(negedge clk);
    end
    rready = 0;
  endtask

  task automatic test_reset();
    logic [1:0] resp;
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({awready, wready, bvalid, bresp, arready, rvalid, rlast, rresp, rdata} !== 42'd0)
      begin n_bad++; $display("FAIL reset_outputs got=%h want 0", {awready, wready, bvalid, bresp, arready, rvalid, rlast, rresp, rdata}); end
    rst_n = 1;
    @(negedge clk);
    n_cmp++;
    if ({awready, arready} !== 2'b11) begin n_bad++; $display("FAIL ready_after_reset got=%b want 11", {awready, arready}); end
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom | 32'd1; ws[i] = 4'hF; end
    wr_req(4'h0, 3, 4, 0); wr_resp(0, resp);
    // open a write and a read burst, then pull reset in the middle of them
    awvalid = 1; awaddr = 0; awlen = 3; arvalid = 1; araddr = 0; arlen = 3;
    @(negedge clk); awvalid = 0; arvalid = 0;
    n_cmp++;
    if ({wready, rvalid} !== 2'b11) begin n_bad++; $display("FAIL midburst_open got=%b want 11", {wready, rvalid}); end
    wvalid = 1; wdata = 32'h1234_5678; wstrb = 4'hF; wlast = 0;
    @(negedge clk); wvalid = 0;
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({awready, wready, bvalid, bresp, arready, rvalid, rlast, rresp, rdata} !== 42'd0)
      begin n_bad++; $display("FAIL midburst_reset_async got=%h want 0", {awready, wready, bvalid, bresp, arready, rvalid, rlast, rresp, rdata}); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({awready, wready, bvalid, bresp, arready, rvalid, rlast, rresp, rdata} !== 42'd0)
      begin n_bad++; $display("FAIL midburst_reset_held got=%h want 0", {awready, wready, bvalid, bresp, arready, rvalid, rlast, rresp, rdata}); end
    rst_n = 1;
    for (int i = 0; i < 4; i++) mem_m[i] = 0;
    @(negedge clk);
    n_cmp++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b10010)
      begin n_bad++; $display("FAIL post_reset_state got=%b want 10010", {awready, wready, bvalid, arready, rvalid}); end
    axi_read(4'h0, 3, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd[i] !== 32'd0) begin n_bad++; $display("FAIL mem_cleared word=%0d got=%h want 0", i, rd[i]); end
    end
  endtask

  task automatic test_single();
    logic [1:0] resp;
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    wr_req(4'h4, 0, 1, 0); wr_resp(0, resp); m_write(4'h4, 0, 1);
    n_cmp++;
    if (resp !== 2'b00) begin n_bad++; $display("FAIL single_bresp got=%b want 00", resp); end
    axi_read(4'h4, 0, 0);
    n_cmp++;
    if (rd[0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_rdata got=%h want deadbeef", rd[0]); end
    n_cmp++;
    if (rl[0] !== 1'b1) begin n_bad++; $display("FAIL single_rlast got=%b want 1", rl[0]); end
    n_cmp++;
    if (r_lat != 1) begin n_bad++; $display("FAIL single_rlatency got=%0d want 1", r_lat); end
  endtask

  task automatic test_burst_wrap();
    logic [1:0] resp;
    for (int i = 0; i < 4; i++) begin wd[i] = i + 1; ws[i] = 4'hF; end
    wr_req(4'h8, 3, 4, 0); wr_resp(0, resp); m_write(4'h8, 3, 4);
    n_cmp++;
    if (resp !== 2'b00) begin n_bad++; $display("FAIL wrap_bresp got=%b want 00", resp); end
    axi_read(4'h0, 3, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd[i] !== 32'(((i + 2) % 4) + 1) || rl[i] !== (i == 3))
        begin n_bad++; $display("FAIL wrap_read beat=%0d got=%h/%b want %h/%b", i, rd[i], rl[i], ((i + 2) % 4) + 1, i == 3); end
    end
  endtask

  task automatic test_strobe_backpressure();
    logic [1:0] resp;
    int n = 0;
    wd[0] = 0; ws[0] = 4'hF;
    wr_req(4'h0, 0, 1, 0); wr_resp(0, resp); m_write(4'h0, 0, 1);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    wr_req(4'h0, 0, 1, 0); wr_resp(0, resp); m_write(4'h0, 0, 1);
    arvalid = 1; araddr = 0; arlen = 0;
    while (!arready && n < 300) begin @(negedge clk); n++; end
    @(negedge clk); arvalid = 0; rready = 0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({rvalid, rlast, rdata} !== {2'b11, 32'h00BB_00DD})
        begin n_bad++; $display("FAIL strobe_hold cyc=%0d got=%b/%b/%h want 1/1/00bb00dd", i, rvalid, rlast, rdata); end
      @(negedge clk);
    end
    rready = 1;
    @(negedge clk); rready = 0;
    n_cmp++;
    if ({rvalid, rlast, rdata, arready} !== {2'b00, 32'd0, 1'b1})
      begin n_bad++; $display("FAIL after_rlast got=%b/%b/%h/%b want 0/0/0/1", rvalid, rlast, rdata, arready); end
  endtask

  task automatic test_wlast_mismatch();
    logic [1:0] resp;
    logic [3:0] a = 4'($urandom);
    int n = 0;
    wd[0] = $urandom; ws[0] = 4'hF;
    wr_req(a, 1, 1, 0); m_write(a, 1, 1);
    while (!bvalid && n < 300) begin @(negedge clk); n++; end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({bvalid, bresp} !== 3'b110) begin n_bad++; $display("FAIL short_b_hold cyc=%0d got=%b want 110", i, {bvalid, bresp}); end
      @(negedge clk);
    end
    bready = 1;
    @(negedge clk); bready = 0;
    n_cmp++;
    if ({bvalid, bresp} !== 3'b000) begin n_bad++; $display("FAIL short_b_release got=%b want 000", {bvalid, bresp}); end
    for (int i = 0; i < 3; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    wr_req(a, 0, 3, 0); wr_resp(0, resp); m_write(a, 0, 3);
    n_cmp++;
    if (resp !== 2'b10) begin n_bad++; $display("FAIL long_bresp got=%b want 10", resp); end
    axi_read(a, 3, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd[i] !== mem_m[(int'(a[3:2]) + i) % 4])
        begin n_bad++; $display("FAIL long_extra_beats word=%0d got=%h want %h", i, rd[i], mem_m[(int'(a[3:2]) + i) % 4]); end
    end
  endtask

  task automatic test_random();
    logic [1:0] resp;
    for (int k = 0; k < 1000; k++) begin
      logic [3:0] a = 4'($urandom);
      int len = ($urandom_range(99) == 0) ? 255 : $urandom_range(7);
      if ($urandom_range(9) < 6) begin
        int nb = ($urandom_range(9) == 0) ? $urandom_range(len + 3, 1) : len + 1;
        for (int i = 0; i < nb; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        wr_req(a, len, nb, 1); wr_resp(1, resp); m_write(a, len, nb);
        n_cmp++;
        if (resp !== ((nb == len + 1) ? 2'b00 : 2'b10))
          begin n_bad++; $display("FAIL rand_bresp k=%0d len=%0d beats=%0d got=%b", k, len, nb, resp); end
      end else begin
        axi_read(a, len, 1);
        for (int i = 0; i <= len; i++) begin
          n_cmp++;
          if (rd[i] !== mem_m[(int'(a[3:2]) + i) % 4] || rl[i] !== (i == len))
            begin n_bad++; $display("FAIL rand_read k=%0d beat=%0d got=%h/%b want %h/%b", k, i, rd[i], rl[i], mem_m[(int'(a[3:2]) + i) % 4], i == len); end
        end
      end
    end
    n_cmp++;
    if (viol != 0) begin n_bad++; $display("FAIL protocol_rules violations=%0d want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_wrap();
    test_strobe_backpressure();
    test_wlast_mismatch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1);
  end
endmodule
